crossbar_2x2_buf: RTL and testbench
===================================

CROSSBAR_2X2_BUF -- requirements
Module: crossbar_2x2_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width of every channel.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the per-output FIFO depth; DEPTH SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have ports in1_data and in2_data, input, WIDTH bits each: input channel payloads.
REQ-006 The block SHALL have ports in1_valid and in2_valid, input, 1 bit each: the input payload is offered.
REQ-007 The block SHALL have ports in1_ready and in2_ready, output, 1 bit each: the input payload is accepted this cycle.
REQ-008 The block SHALL have ports out1_data and out2_data, output, WIDTH bits each: FIFO head payloads.
REQ-009 The block SHALL have ports out1_valid and out2_valid, output, 1 bit each: the FIFO head is valid.
REQ-010 The block SHALL have ports out1_ready and out2_ready, input, 1 bit each: the downstream consumer accepts the head.
REQ-011 The block SHALL have port mode, input, 2 bits: requested routing, where 00 = bar, 01 = cross, 10 = broadcast in1, 11 = broadcast in2.
REQ-012 The block SHALL have port mode_load, input, 1 bit: request to load mode.
REQ-013 The block SHALL have port cur_mode, output, 2 bits: the active routing register.
REQ-014 The block SHALL have port busy, output, 1 bit: at least one output FIFO is non-empty.

Function
REQ-015 Routing SHALL follow cur_mode: bar maps in1 to FIFO1 and in2 to FIFO2; cross maps in1 to FIFO2 and in2 to FIFO1; broadcast in1 or broadcast in2 writes the source input to both FIFOs.
REQ-016 An input transfer SHALL occur on a clock edge where inN_valid and inN_ready are both 1; a transfer pushes inN_data into its routed FIFO or FIFOs.
REQ-017 In bar or cross mode, inN_ready SHALL be 1 exactly when its target FIFO is not full; pops in the same cycle do not raise ready, so there is no full-FIFO bypass.
REQ-018 In broadcast mode, the source input ready SHALL be 1 only when both FIFOs are not full; the write to both FIFOs SHALL be atomic.
REQ-019 In broadcast mode, the non-source input ready SHALL be 0.
REQ-020 The output FIFOs SHALL be first-word-fall-through: outN_valid is 1 exactly when FIFO N is non-empty, and outN_data equals the FIFO head.
REQ-021 A pop SHALL occur when outN_valid and outN_ready are both 1.
REQ-022 Data accepted at edge k SHALL be visible on the output after edge k, giving one cycle of latency.
REQ-023 Order within each FIFO SHALL be preserved.
REQ-024 A simultaneous push and pop on a non-empty, non-full FIFO SHALL leave occupancy unchanged.
REQ-025 A simultaneous push and pop on an empty FIFO SHALL be impossible, because valid is 0 when empty.
REQ-026 The FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-027 Occupancy SHALL be tracked with log2(DEPTH)+1 bits.
REQ-028 The mode controller SHALL be a two-state FSM with states RUN and DRAIN.
REQ-029 In RUN, if mode_load=1 and mode differs from cur_mode, the FSM SHALL enter DRAIN and latch mode as pending; a mode_load equal to cur_mode SHALL be ignored.
REQ-030 In DRAIN, both in1_ready and in2_ready SHALL be 0.
REQ-031 In DRAIN, pops SHALL continue normally.
REQ-032 In DRAIN, further mode_load pulses SHALL overwrite the pending value.
REQ-033 The FSM SHALL leave DRAIN to RUN on the edge where both FIFOs are empty, loading cur_mode from pending; the new routing applies from the next cycle.
REQ-034 If both FIFOs are empty when mode_load is asserted in RUN, the FSM SHALL still pass through DRAIN for exactly one cycle.
REQ-035 The value of outN_data while outN_valid=0 is a don't-care and SHALL NOT be checked.

Reset
REQ-036 When rst_n=0, the block SHALL immediately clear both FIFOs (pointers and counts to 0), set the FSM to RUN, set cur_mode and pending to 00, and drive out1_valid=0, out2_valid=0, busy=0, in1_ready=0 and in2_ready=0.
REQ-037 After rst_n deasserts, the block SHALL drive in1_ready=1 and in2_ready=1 (bar mode, FIFOs empty).
REQ-038 Reset asserted mid-transfer or in DRAIN SHALL discard all buffered data and any pending mode change.

Verification (WIDTH=4, DEPTH=2)
REQ-039 The bench SHALL cover bar mode: in1=0x3 and in2=0x5 offered in the same cycle with outputs ready -> out1=0x3 and out2=0x5, both valid one cycle later.
REQ-040 The bench SHALL cover cross mode: after loading 01, in1=0xA and in2=0xC -> out1=0xC and out2=0xA; the bench confirms cur_mode=01 after the one-cycle DRAIN.
REQ-041 The bench SHALL cover broadcast in1: mode 10, out2_ready=0, in1 sends 0x1, 0x2, 0x3 -> in1_ready drops after 2 accepts; in2_ready stays 0 throughout; both FIFOs hold 0x1 and 0x2.
REQ-042 The bench SHALL cover full and wrap: in bar mode with out1_ready=0, push 0x0 and 0x1 -> in1_ready=0; then pop one and push 0x2, repeated 5 times -> output order is 0,1,2,... with no loss or duplication.
REQ-043 The bench SHALL cover a mode change while busy: FIFO1 holds 2 words when mode_load=1 with mode=01 -> inputs are stalled until both pops complete, then cur_mode=01.
REQ-044 The bench SHALL cover reset mid-operation: rst_n pulsed low while in DRAIN with data buffered -> all valids are 0, cur_mode=00 and busy=0 immediately.

Source files
------------

// File: rtl/crossbar_2x2_buf.sv
// 2x2 buffered crossbar: per-output FWFT FIFOs and a drain-before-switch
// routing controller (bar, cross, broadcast in1, broadcast in2).

module xbar_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0] count;

    assign empty = (count == '0);
    assign full = (count == FULL_CNT);
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers are AW bits wide, so increments wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop) rptr <= rptr + PTR_ONE;
            unique case ({push, pop})
                2'b10: count <= count + CNT_ONE;
                2'b01: count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

module crossbar_2x2_buf #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1_data,
    input  logic [WIDTH-1:0] in2_data,
    input  logic             in1_valid,
    input  logic             in2_valid,
    output logic             in1_ready,
    output logic             in2_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [WIDTH-1:0] out2_data,
    output logic             out1_valid,
    output logic             out2_valid,
    input  logic             out1_ready,
    input  logic             out2_ready,
    input  logic [1:0]       mode,
    input  logic             mode_load,
    output logic [1:0]       cur_mode,
    output logic             busy
);
    localparam logic [1:0] M_BAR = 2'b00;
    localparam logic [1:0] M_CROSS = 2'b01;
    localparam logic [1:0] M_BC1 = 2'b10;
    localparam logic [1:0] M_BC2 = 2'b11;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [1:0] pend_q, pend_d;

    logic push1, push2, pop1, pop2;
    logic [WIDTH-1:0] wdata1, wdata2;
    logic empty1, empty2, full1, full2;
    logic xfer1, xfer2;

    assign out1_valid = !empty1;
    assign out2_valid = !empty2;
    assign pop1 = out1_valid && out1_ready;
    assign pop2 = out2_valid && out2_ready;
    assign busy = !empty1 || !empty2;
    assign cur_mode = mode_q;

    // Readiness never looks at same-cycle pops: a full FIFO stalls its inputs.
    always_comb begin
        in1_ready = 1'b0;
        in2_ready = 1'b0;
        if (rst_n && state_q == RUN) begin
            unique case (mode_q)
                M_BAR: begin
                    in1_ready = !full1;
                    in2_ready = !full2;
                end
                M_CROSS: begin
                    in1_ready = !full2;
                    in2_ready = !full1;
                end
                M_BC1: in1_ready = !full1 && !full2;
                M_BC2: in2_ready = !full1 && !full2;
                default: ;
            endcase
        end
    end

    assign xfer1 = in1_valid && in1_ready;
    assign xfer2 = in2_valid && in2_ready;

    always_comb begin
        push1 = 1'b0;
        push2 = 1'b0;
        wdata1 = in1_data;
        wdata2 = in2_data;
        unique case (mode_q)
            M_BAR: begin
                push1 = xfer1;
                push2 = xfer2;
            end
            M_CROSS: begin
                push1 = xfer2;
                push2 = xfer1;
                wdata1 = in2_data;
                wdata2 = in1_data;
            end
            M_BC1: begin
                push1 = xfer1;
                push2 = xfer1;
                wdata2 = in1_data;
            end
            M_BC2: begin
                push1 = xfer2;
                push2 = xfer2;
                wdata1 = in2_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pend_d = pend_q;
        mode_d = mode_q;
        unique case (state_q)
            RUN: begin
                if (mode_load && mode != mode_q) begin
                    state_d = DRAIN;
                    pend_d = mode;
                end
            end
            DRAIN: begin
                if (mode_load) pend_d = mode;
                if (!busy) begin
                    state_d = RUN;
                    mode_d = pend_d;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            mode_q <= M_BAR;
            pend_q <= M_BAR;
        end else begin
            state_q <= state_d;
            mode_q <= mode_d;
            pend_q <= pend_d;
        end
    end

    xbar_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst_n(rst_n), .push(push1), .wdata(wdata1),
        .pop(pop1), .rdata(out1_data), .empty(empty1), .full(full1)
    );

    xbar_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk(clk), .rst_n(rst_n), .push(push2), .wdata(wdata2),
        .pop(pop2), .rdata(out2_data), .empty(empty2), .full(full2)
    );
endmodule

// File: tb/tb_crossbar_2x2_buf.sv
// Directed bench for crossbar_2x2_buf (WIDTH=4, DEPTH=2).
// Inputs change 1 time unit after a rising edge; checks follow 1 unit later.

module tb_crossbar_2x2_buf;
    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] in1_data, in2_data;
    logic in1_valid, in2_valid;
    logic in1_ready, in2_ready;
    logic [3:0] out1_data, out2_data;
    logic out1_valid, out2_valid;
    logic out1_ready, out2_ready;
    logic [1:0] mode;
    logic mode_load;
    logic [1:0] cur_mode;
    logic busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    crossbar_2x2_buf #(.WIDTH(4), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in1_data(in1_data), .in2_data(in2_data),
        .in1_valid(in1_valid), .in2_valid(in2_valid),
        .in1_ready(in1_ready), .in2_ready(in2_ready),
        .out1_data(out1_data), .out2_data(out2_data),
        .out1_valid(out1_valid), .out2_valid(out2_valid),
        .out1_ready(out1_ready), .out2_ready(out2_ready),
        .mode(mode), .mode_load(mode_load),
        .cur_mode(cur_mode), .busy(busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic load_mode(input logic [1:0] m);
        mode = m;
        mode_load = 1'b1;
        step();
        mode_load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in1_data = '0; in2_data = '0;
        in1_valid = 1'b0; in2_valid = 1'b0;
        out1_ready = 1'b0; out2_ready = 1'b0;
        mode = 2'b00; mode_load = 1'b0;
        settle();
        chk("rst_out1_valid", out1_valid, 0);
        chk("rst_out2_valid", out2_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in1_ready", in1_ready, 0);
        chk("rst_in2_ready", in2_ready, 0);
        chk("rst_cur_mode", cur_mode, 0);
        step();
        step();
        rst_n = 1'b1;
        settle();
        chk("post_rst_in1_ready", in1_ready, 1);
        chk("post_rst_in2_ready", in2_ready, 1);

        // bar
        out1_ready = 1'b1; out2_ready = 1'b1;
        in1_data = 4'h3; in2_data = 4'h5;
        in1_valid = 1'b1; in2_valid = 1'b1;
        step();
        in1_valid = 1'b0; in2_valid = 1'b0;
        settle();
        chk("bar_out1_valid", out1_valid, 1);
        chk("bar_out1_data", out1_data, 8'h3);
        chk("bar_out2_valid", out2_valid, 1);
        chk("bar_out2_data", out2_data, 8'h5);
        step();
        chk("bar_drained", busy, 0);

        // cross, one-cycle DRAIN with empty FIFOs
        load_mode(2'b01);
        settle();
        chk("cross_drain_in1_ready", in1_ready, 0);
        chk("cross_drain_cur_mode", cur_mode, 0);
        step();
        chk("cross_cur_mode", cur_mode, 1);
        in1_data = 4'hA; in2_data = 4'hC;
        in1_valid = 1'b1; in2_valid = 1'b1;
        step();
        in1_valid = 1'b0; in2_valid = 1'b0;
        settle();
        chk("cross_out1_data", out1_data, 8'hC);
        chk("cross_out2_data", out2_data, 8'hA);
        step();
        chk("cross_drained", busy, 0);

        // broadcast in1 with both outputs stalled
        load_mode(2'b10);
        step();
        chk("bc1_cur_mode", cur_mode, 2);
        out1_ready = 1'b0; out2_ready = 1'b0;
        in1_valid = 1'b1; in1_data = 4'h1;
        settle();
        chk("bc1_rdy_a", in1_ready, 1);
        chk("bc1_in2_rdy_a", in2_ready, 0);
        step();
        in1_data = 4'h2;
        settle();
        chk("bc1_rdy_b", in1_ready, 1);
        chk("bc1_in2_rdy_b", in2_ready, 0);
        step();
        in1_data = 4'h3;
        settle();
        chk("bc1_rdy_full", in1_ready, 0);
        chk("bc1_in2_rdy_c", in2_ready, 0);
        step();
        chk("bc1_rdy_full2", in1_ready, 0);
        in1_valid = 1'b0;
        chk("bc1_f1_head", out1_data, 8'h1);
        chk("bc1_f2_head", out2_data, 8'h1);
        out1_ready = 1'b1; out2_ready = 1'b1;
        step();
        chk("bc1_f1_next", out1_data, 8'h2);
        chk("bc1_f2_next", out2_data, 8'h2);
        step();
        chk("bc1_drained", busy, 0);

        // full and wrap in bar mode
        out1_ready = 1'b0; out2_ready = 1'b0;
        load_mode(2'b00);
        step();
        chk("wrap_cur_mode", cur_mode, 0);
        in1_valid = 1'b1; in1_data = 4'h0;
        step();
        in1_data = 4'h1;
        step();
        in1_valid = 1'b0;
        chk("wrap_full_rdy", in1_ready, 0);
        for (int i = 0; i < 5; i++) begin
            chk("wrap_head", out1_data, 8'(i));
            out1_ready = 1'b1;
            step();
            out1_ready = 1'b0;
            in1_valid = 1'b1;
            in1_data = 4'(i + 2);
            settle();
            chk("wrap_push_rdy", in1_ready, 1);
            step();
            in1_valid = 1'b0;
        end
        chk("wrap_head5", out1_data, 8'h5);
        out1_ready = 1'b1;
        step();
        chk("wrap_head6", out1_data, 8'h6);
        step();
        chk("wrap_empty", out1_valid, 0);

        // mode change while FIFO1 holds two words
        out1_ready = 1'b0;
        in1_valid = 1'b1; in1_data = 4'h7;
        step();
        in1_data = 4'h8;
        step();
        in1_valid = 1'b0;
        load_mode(2'b01);
        settle();
        chk("busy_stall_in1", in1_ready, 0);
        chk("busy_stall_in2", in2_ready, 0);
        chk("busy_mode_held", cur_mode, 0);
        chk("busy_head7", out1_data, 8'h7);
        out1_ready = 1'b1;
        step();
        chk("busy_head8", out1_data, 8'h8);
        chk("busy_stall2", in1_ready, 0);
        step();
        chk("busy_empty_drain", cur_mode, 0);
        chk("busy_stall3", in2_ready, 0);
        step();
        chk("busy_new_mode", cur_mode, 1);
        chk("busy_resume", in1_ready, 1);

        // reset while in DRAIN with data buffered
        out1_ready = 1'b0; out2_ready = 1'b0;
        in1_valid = 1'b1; in1_data = 4'h9;
        step();
        in1_valid = 1'b0;
        load_mode(2'b00);
        settle();
        chk("mid_busy", busy, 1);
        chk("mid_drain_rdy", in1_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out1_valid", out1_valid, 0);
        chk("mid_rst_out2_valid", out2_valid, 0);
        chk("mid_rst_cur_mode", cur_mode, 0);
        chk("mid_rst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_rst_after_rdy", in2_ready, 1);
        chk("mid_rst_after_mode", cur_mode, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
